// File: rtl/vga_pixel_gen_pkg.sv
// vga_pixel_gen_pkg: VGA geometry, bar palette and box bounce helper.
// Shared with the timing generator and the other pattern blocks.
package vga_pixel_gen_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    // Index 0 (rightmost) is white, index 7 (leftmost) is black; each entry is {R,G,B}.
    localparam logic [7:0][11:0] BAR_COLOURS = {
        12'h000, 12'h00F, 12'hF00, 12'hF0F, 12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
    };

    // Returns {new_dir, new_pos}. dir 1 means moving toward hi. Math is 11-bit so nothing wraps.
    function automatic logic [10:0] bounce(input logic [9:0] pos, input logic dir,
                                           input int hi_lim, input int step);
        logic [10:0] hi, st, p, s;
        hi = 11'(hi_lim);
        st = 11'(step);
        p  = {1'b0, pos};
        s  = p + st;
        return dir ? ((s >= hi) ? {1'b0, 10'(hi)} : {1'b1, 10'(s)})
                   : ((p <= st) ? {1'b1, 10'd0}   : {1'b0, 10'(p - st)});
    endfunction

endpackage

// File: rtl/vga_box_mover.sv
// vga_box_mover: bouncing square position, stepped once per frame_tick.
module vga_box_mover
    import vga_pixel_gen_pkg::*;
#(
    parameter int LIMIT_X  = H_ACTIVE,
    parameter int LIMIT_Y  = V_ACTIVE,
    parameter int BOX_SIZE = 32,
    parameter int STEP     = 2,
    parameter int X0       = 100,
    parameter int Y0       = 50
) (
    input  logic       clk_25MHZ,
    input  logic       reset,
    input  logic       frame_tick,
    output logic [9:0] box_x,
    output logic [9:0] box_y
);

    logic        dir_x, dir_y;
    logic [10:0] nx, ny;

    always_comb begin
        nx = bounce(box_x, dir_x, LIMIT_X - BOX_SIZE, STEP);
        ny = bounce(box_y, dir_y, LIMIT_Y - BOX_SIZE, STEP);
    end

    always_ff @(posedge clk_25MHZ) begin
        if (reset) begin
            box_x <= 10'(X0);
            box_y <= 10'(Y0);
            dir_x <= 1'b1;
            dir_y <= 1'b1;
        end else if (frame_tick) begin
            {dir_x, box_x} <= nx;
            {dir_y, box_y} <= ny;
        end
    end

endmodule

// File: rtl/vga_pixel_gen.sv
// vga_pixel_gen: rebuilds pixel x/y from VGA strobes and draws colour bars or a bouncing square.
module vga_pixel_gen
    import vga_pixel_gen_pkg::*;
#(
    parameter int BAR_WIDTH = 80,
    parameter int BOX_SIZE  = 32,
    parameter int STEP      = 2,
    parameter int BOX_X0    = 100,
    parameter int BOX_Y0    = 50
) (
    input  logic       clk_25MHZ,
    input  logic       reset,
    input  logic       horizontal_sync,
    input  logic       vertical_sync,
    input  logic       display_Area,
    input  logic       pattern_sel,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       frame_tick
);

    logic        de_d, vs_d, line_end, frame_start, adv, in_box;
    logic [9:0]  x, box_x, box_y;
    logic [8:0]  y;
    logic [6:0]  bar_cnt;
    logic [2:0]  bar_idx;
    logic [11:0] pix;

    vga_box_mover #(
        .LIMIT_X (H_ACTIVE),
        .LIMIT_Y (V_ACTIVE),
        .BOX_SIZE(BOX_SIZE),
        .STEP    (STEP),
        .X0      (BOX_X0),
        .Y0      (BOX_Y0)
    ) u_mover (
        .clk_25MHZ (clk_25MHZ),
        .reset     (reset),
        .frame_tick(frame_tick),
        .box_x     (box_x),
        .box_y     (box_y)
    );

    always_comb begin
        line_end    = de_d & ~display_Area;
        frame_start = vs_d & ~vertical_sync;
        adv         = display_Area && (x != 10'(H_ACTIVE - 1));
        in_box      = ({1'b0, x} >= {1'b0, box_x}) && ({1'b0, x} < {1'b0, box_x} + 11'(BOX_SIZE)) &&
                      ({2'b0, y} >= {1'b0, box_y}) && ({2'b0, y} < {1'b0, box_y} + 11'(BOX_SIZE));
        pix         = !display_Area ? 12'h000 :
                      pattern_sel   ? (in_box ? 12'hFF0 : 12'h003) : BAR_COLOURS[bar_idx];
    end

    // x and the bar counters share one advance condition so bars stop with x at saturation.
    always_ff @(posedge clk_25MHZ) begin
        if (reset) begin
            {red, green, blue} <= 12'h000;
            hsync_out  <= 1'b1;
            vsync_out  <= 1'b1;
            frame_tick <= 1'b0;
            de_d       <= 1'b0;
            vs_d       <= 1'b1;
            x          <= '0;
            y          <= '0;
            bar_cnt    <= '0;
            bar_idx    <= '0;
        end else begin
            de_d       <= display_Area;
            vs_d       <= vertical_sync;
            frame_tick <= frame_start;
            hsync_out  <= horizontal_sync;
            vsync_out  <= vertical_sync;
            {red, green, blue} <= pix;
            if (line_end) begin
                x       <= '0;
                bar_cnt <= '0;
                bar_idx <= '0;
            end else if (adv) begin
                x       <= x + 10'd1;
                bar_cnt <= (bar_cnt == 7'(BAR_WIDTH - 1)) ? 7'd0 : bar_cnt + 7'd1;
                bar_idx <= (bar_cnt == 7'(BAR_WIDTH - 1)) ? bar_idx + 3'd1 : bar_idx;
            end
            if (frame_start)
                y <= '0;
            else if (line_end && (y != 9'(V_ACTIVE - 1)))
                y <= y + 9'd1;
        end
    end

endmodule

// File: doc/vga_pixel_gen.md
Name: vga_pixel_gen

Overview:
- Downstream consumer of the VGA timing generator; one instance per display path.
- Takes the timing generator's active-low horizontal_sync, active-low vertical_sync and display_Area strobes.
- Rebuilds pixel x/y coordinates and draws one of two patterns into 4-bit-per-channel RGB:
  - colour bars;
  - a bouncing square over a dark background.
- Delays the syncs so they stay aligned with the registered RGB.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- BAR_WIDTH, 80, pixels per colour bar (H_ACTIVE/8)
- BOX_SIZE, 32, square edge length in pixels
- STEP, 2, pixels the square moves per frame on each axis
- BOX_X0, 100, square x position after reset
- BOX_Y0, 50, square y position after reset

Ports:
- clk_25MHZ  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- horizontal_sync  in  1  active-low hsync from timing generator
- vertical_sync  in  1  active-low vsync from timing generator
- display_Area  in  1  high during visible pixels
- pattern_sel  in  1  0 = colour bars, 1 = bouncing square
- red  out  4  red channel, registered
- green  out  4  green channel, registered
- blue  out  4  blue channel, registered
- hsync_out  out  1  horizontal_sync delayed 1 cycle
- vsync_out  out  1  vertical_sync delayed 1 cycle
- frame_tick  out  1  one-cycle pulse at the start of each vsync

Behaviour:
- **Clocking and reset.** Single clock domain.
- **Synchronous reset**, applied on a clk_25MHZ edge with reset=1, forces:
  - red/green/blue = 0; hsync_out = 1; vsync_out = 1; frame_tick = 0;
  - x = 0, y = 0, bar_cnt = 0, bar_idx = 0;
  - box_x = BOX_X0, box_y = BOX_Y0, dir_x = +, dir_y = +;
  - de_d = 0; vs_d = 1.
- **Reset mid-frame.** The coordinates are wrong until the next vsync falling edge. That is acceptable; no other recovery is required.
- **Edge detect.** Register display_Area as de_d and vertical_sync as vs_d.
  - Line end = de_d & ~display_Area.
  - Frame start = vs_d & ~vertical_sync; frame_tick is registered from this, so it is 1 cycle late.
- **x counter (10 bit).**
  - Increments on every cycle with display_Area = 1.
  - Clears to 0 on line end.
  - Saturates at H_ACTIVE-1 if display_Area stays high too long.
- **y counter (9 bit).**
  - Increments on line end, saturating at V_ACTIVE-1.
  - Clears on frame start. Frame start has priority over a coincident line end.
- **Bar counters.** bar_cnt (7 bit) and bar_idx (3 bit) advance with x.
  - When bar_cnt = BAR_WIDTH-1, bar_cnt returns to 0 and bar_idx increments.
  - Both clear on line end.
  - No divider is permitted.
- **Bar colours, bar_idx 0..7 (R,G,B):** white F,F,F; yellow F,F,0; cyan 0,F,F; green 0,F,0; magenta F,0,F; red F,0,0; blue 0,0,F; black 0,0,0.
- **Square mode.**
  - A pixel is inside when box_x ≤ x < box_x+BOX_SIZE and box_y ≤ y < box_y+BOX_SIZE.
  - Inside colour = F,F,0; outside colour = 0,0,3.
- **Square motion.** Updated only on the frame_tick cycle; x and y are independent.
  - Moving +: if box_x+STEP ≥ H_ACTIVE-BOX_SIZE, set box_x = H_ACTIVE-BOX_SIZE and set dir_x to −; else box_x += STEP.
  - Moving −: if box_x ≤ STEP, set box_x = 0 and set dir_x to +; else box_x −= STEP.
  - y axis: same rule with V_ACTIVE.
  - Arithmetic is 11-bit to avoid wrap.
- **Output stage.**
  - RGB is registered from the current-cycle x, y and bar_idx selected by the display_Area input, giving 1-cycle latency.
  - If display_Area = 0, RGB = 0 regardless of mode.
  - hsync_out and vsync_out are single-register delays, so they align with RGB.
- **pattern_sel** is sampled every cycle. A change takes effect on the next pixel; no frame boundary is required.

Decomposition:
- Shared package: H_ACTIVE, V_ACTIVE and the 8-entry bar colour constant table, so the timing generator and other pattern blocks reuse them.
- One natural sub-module, vga_box_mover: box_x/box_y/direction state, updated on frame_tick. Parameters: BOX_SIZE, STEP, limits. Outputs: box_x, box_y.
- Coordinate counters and output register stay in the top.

Test Plan:
1. **Reset.** Hold reset for 3 cycles with the timing generator running.
   - Expect RGB = 0, hsync_out = 1, vsync_out = 1, frame_tick = 0.
   - Expect the internal box at (100, 50).
2. **Colour bars.** pattern_sel = 0; drive one visible line.
   - Pixel x = 0..79 gives F,F,F.
   - x = 80 gives F,F,0.
   - x = 560..639 gives 0,0,0.
   - After display_Area falls, RGB = 0 one cycle later and x restarts at 0 on the next line.
3. **Alignment.** Toggle horizontal_sync at an arbitrary cycle.
   - hsync_out follows exactly 1 cycle later.
   - The first visible pixel's RGB appears 1 cycle after display_Area rises.
4. **Square draw.** pattern_sel = 1, box at reset position, frame 0.
   - Line y = 50, x = 100..131 gives F,F,0.
   - x = 99 and x = 132 give 0,0,3.
   - Line 49 is entirely 0,0,3.
5. **Bounce at right edge.** Force the box to box_x = 606 with dir +, then issue one frame_tick.
   - Expect box_x = 608 and dir = −.
   - Next tick gives 606.
   - Similarly box_y = 1 with dir − gives 0, then dir + and 2.
6. **Coincident events and motion.** Assert line end and frame start in the same cycle → y = 0.
   - Count 10 frames with no edge hit → box_x = 120, box_y = 70.
